// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end.
// Fetch buffer entry layout and branch/jump target helpers.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int INSTR_W    = 32;
  localparam int WORD_SHIFT = 2;
  localparam int JTGT_W     = 26;
  localparam int JREG_LSB   = 28;
  localparam int JREG_W     = 4;

  typedef struct packed {
    logic [INSTR_W-1:0] pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] br_target(
    input logic [31:0] seq_pc,
    input logic [15:0] imm
  );
    return seq_pc + ({{16{imm[15]}}, imm} << WORD_SHIFT);
  endfunction

  function automatic logic [31:0] j_target(
    input logic [31:0]       seq_pc,
    input logic [JTGT_W-1:0] idx
  );
    return {seq_pc[JREG_LSB +: JREG_W], idx, {WORD_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: imem request/response channel plus decode handshake.
// master = fetch stage, slave = memory and decoder side.
interface instr_fetch_if;
  import mips_pkg::*;

  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [INSTR_W-1:0] imem_req_addr;
  logic               imem_resp_valid;
  logic [INSTR_W-1:0] imem_resp_data;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               dobranch;
  logic               dojump;

  modport master (
    output imem_req_valid, imem_req_addr,
    output instr, instr_pc, instr_valid,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data,
    input  instr_ready, dobranch, dojump
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    input  instr, instr_pc, instr_valid,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data,
    output instr_ready, dobranch, dojump
  );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-register instruction buffer; entry 0 is the registered head.
// Flush wins over push/pop in the same cycle.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 3,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [CW-1:0] pop_w;
  logic [AW-1:0] widx;

  assign pop_w = CW'(pop);
  assign widx  = AW'(count - pop_w);
  assign head  = mem[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
      end
      // write lands after the shift so a pop+push keeps order
      if (push) mem[widx] <= din;
      count <= count + CW'(push) - pop_w;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues credit-limited imem requests,
// buffers words for decode and squashes wrong-path fetches on redirect.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 3
) (
  input logic           clk,
  input logic           reset_n,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   seq_pc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] out_next;
  logic [CW:0]   used;
  logic          req_fire;
  logic          resp_fire;
  logic          push;
  logic          pop;
  logic          redirect;
  fetch_entry_t  head;
  fetch_entry_t  din;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (redirect),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .count (fifo_count)
  );

  assign used = {1'b0, outstanding} + {1'b0, fifo_count};

  assign bus.imem_req_valid = reset_n && (used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.instr_valid    = fifo_count != '0;
  assign bus.instr          = head.word;
  assign bus.instr_pc       = head.pc;

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  // a response with nothing in flight is a protocol error and is ignored
  assign resp_fire = bus.imem_resp_valid && (outstanding != '0);
  assign pop       = bus.instr_valid && bus.instr_ready;
  assign redirect  = pop && (bus.dobranch || bus.dojump);
  assign push      = resp_fire && (drop_cnt == '0) && !redirect;
  assign out_next  = outstanding + CW'(req_fire) - CW'(resp_fire);

  assign din    = '{pc: resp_pc, word: bus.imem_resp_data};
  assign seq_pc = head.pc + 32'd4;
  assign target = bus.dojump
                ? j_target(seq_pc, head.word[JTGT_W-1:0])
                : br_target(seq_pc, head.word[15:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // everything still in flight belongs to the wrong path
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= out_next;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (push) resp_pc <= resp_pc + 32'd4;
        if (resp_fire && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: random-latency memory, random decoder,
// program-flow reference model feeding an expected-instruction queue.
module tb_instr_fetch;
  import mips_pkg::*;

  localparam logic [31:0] RPC = 32'hEFFF_FFF8;
  localparam logic [31:0] JPC = 32'hF000_0000;
  localparam logic [31:0] BPC = 32'hF000_0110;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } req_t;

  logic clk = 1'b0;
  logic reset_n;

  instr_fetch_if ifv();

  instr_fetch #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifv)
  );

  always #5 clk = ~clk;

  int cyc;
  int nchk = 0;
  int nerr = 0;
  int nhs = 0;
  int first_v = -1;
  int mem_rdy, max_lat, dec_rdy, mode;
  logic bogus;

  fetch_entry_t exp_q[$];
  pend_t        pend[$];
  req_t         reqlog[$];
  logic [31:0]  exp_pc;
  int           last_due;
  int           n_redir;
  int           rd_cyc [2];
  logic [31:0]  rd_tgt [2];

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (a == JPC) return 32'h0800_0040;
    if (a == BPC) return 32'h1000_FFFC;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  // architectural next PC straight from the branch/jump rules
  function automatic logic [31:0] model_next(
    input logic [31:0] pc,
    input logic [31:0] w,
    input logic        b,
    input logic        j
  );
    logic [31:0] off;
    if (j) return ((pc + 32'd4) & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    off = 32'(signed'(w[15:0]));
    if (b) return pc + 32'd4 + off * 32'd4;
    return pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_valid", 32'(ifv.imem_req_valid), 32'd0);
    chk("rst_req_addr", ifv.imem_req_addr, RPC);
    chk("rst_instr_valid", 32'(ifv.instr_valid), 32'd0);
    chk("rst_instr", ifv.instr, 32'd0);
    chk("rst_instr_pc", ifv.instr_pc, 32'd0);
  endtask

  task automatic check_redir(input int k, input logic [31:0] tgt);
    int idx = -1;
    foreach (reqlog[i]) begin
      if (idx < 0 && reqlog[i].cyc > rd_cyc[k]) idx = i;
    end
    if (idx < 0) begin
      nchk++;
      nerr++;
      $display("FAIL redir_req%0d: got none expected addr %h", k, tgt);
    end else begin
      chk("redir_req_cyc", 32'(reqlog[idx].cyc), 32'(rd_cyc[k] + 1));
      chk("redir_req_addr", reqlog[idx].addr, tgt);
    end
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // memory: in-order responses, random latency, no backpressure
  always @(negedge clk) begin
    int lat;
    int due;
    if (!reset_n) begin
      pend.delete();
      reqlog.delete();
      last_due = 0;
      ifv.imem_resp_valid = 1'b0;
      ifv.imem_resp_data  = '0;
      ifv.imem_req_ready  = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        ifv.imem_resp_valid = 1'b1;
        ifv.imem_resp_data  = memdata(pend[0].addr);
        void'(pend.pop_front());
      end else if (bogus) begin
        ifv.imem_resp_valid = 1'b1;
        ifv.imem_resp_data  = 32'hDEAD_BEEF;
      end else begin
        ifv.imem_resp_valid = 1'b0;
        ifv.imem_resp_data  = $urandom;
      end
      ifv.imem_req_ready = ($urandom_range(99) < mem_rdy);
      if (ifv.imem_req_valid && ifv.imem_req_ready) begin
        lat = $urandom_range(max_lat);
        due = cyc + 1 + lat;
        if (due < last_due) due = last_due;
        last_due = due;
        pend.push_back('{addr: ifv.imem_req_addr, due: due});
        reqlog.push_back('{cyc: cyc, addr: ifv.imem_req_addr});
      end
    end
  end

  // decoder driver: on each handshake pushes the expected instruction
  always @(negedge clk) begin
    logic        rdy;
    logic [31:0] w;
    int          r;
    if (!reset_n) begin
      exp_q.delete();
      exp_pc = RPC;
      n_redir = 0;
      ifv.instr_ready = 1'b0;
      ifv.dobranch    = 1'b0;
      ifv.dojump      = 1'b0;
    end else begin
      rdy = ($urandom_range(99) < dec_rdy);
      ifv.dobranch = 1'($urandom);
      ifv.dojump   = 1'($urandom);
      if (ifv.instr_valid && rdy) begin
        w = memdata(exp_pc);
        {ifv.dojump, ifv.dobranch} = 2'b00;
        if (mode == 1) begin
          if (exp_pc == JPC && n_redir == 0) {ifv.dojump, ifv.dobranch} = 2'b11;
          if (exp_pc == BPC && n_redir == 1) {ifv.dojump, ifv.dobranch} = 2'b01;
        end else if (mode == 2) begin
          r = $urandom_range(15);
          if (r == 0) {ifv.dojump, ifv.dobranch} = 2'b01;
          if (r == 1) {ifv.dojump, ifv.dobranch} = 2'b10;
          if (r == 2) {ifv.dojump, ifv.dobranch} = 2'b11;
        end
        exp_q.push_back('{pc: exp_pc, word: w});
        exp_pc = model_next(exp_pc, w, ifv.dobranch, ifv.dojump);
        if (ifv.dobranch || ifv.dojump) begin
          if (n_redir < 2) begin
            rd_cyc[n_redir] = cyc;
            rd_tgt[n_redir] = exp_pc;
          end
          n_redir++;
        end
      end
      ifv.instr_ready = rdy;
    end
  end

  // monitor: pops the scoreboard on every decode handshake
  always @(negedge clk) begin
    fetch_entry_t e;
    #2;
    if (!reset_n) begin
      first_v = -1;
    end else begin
      if (ifv.instr_valid && first_v < 0) first_v = cyc;
      if (ifv.instr_valid && ifv.instr_ready) begin
        nhs++;
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL sb_empty: got pc %h expected no instruction", ifv.instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", ifv.instr_pc, e.pc);
          chk("instr", ifv.instr, e.word);
        end
      end
    end
  end

  initial begin
    int h0;
    reset_n = 1'b0;
    bogus   = 1'b0;
    mem_rdy = 100;
    max_lat = 0;
    dec_rdy = 0;
    mode    = 0;
    ifv.imem_req_ready  = 1'b0;
    ifv.imem_resp_valid = 1'b0;
    ifv.imem_resp_data  = '0;
    ifv.instr_ready     = 1'b0;
    ifv.dobranch        = 1'b0;
    ifv.dojump          = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset();

    // decoder stalled: buffer fills, then a stray response is injected
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1 bogus = 1'b1;
    @(posedge clk);
    #1 bogus = 1'b0;
    @(posedge clk);
    #1;
    chk("hold_req_count", 32'(reqlog.size()), 32'd3);
    chk("hold_req_valid", 32'(ifv.imem_req_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (reqlog.size() > i) begin
        chk("first_req_cyc", 32'(reqlog[i].cyc), 32'(i));
        chk("first_req_addr", reqlog[i].addr, RPC + 32'(4 * i));
      end
    end
    chk("first_valid_cyc", 32'(first_v), 32'd2);
    dec_rdy = 100;
    h0 = nhs;
    repeat (20) @(posedge clk);
    #1 chk("throughput", 32'(nhs - h0), 32'd20);

    // directed jump (both asserted) then branch back by 16 bytes
    reset_n = 1'b0;
    mode = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("redirect_count", 32'(n_redir), 32'd2);
    check_redir(0, 32'hF000_0100);
    check_redir(1, 32'hF000_0104);

    // random traffic with a mid-stream reset pulse
    mode    = 2;
    mem_rdy = 60;
    max_lat = 4;
    dec_rdy = 70;
    h0 = nhs;
    repeat (1500) @(posedge clk);
    #3 reset_n = 1'b0;
    #1 chk_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (1500) @(posedge clk);
    #1 chk("random_progress", 32'(nhs - h0 > 200), 32'd1);

    mode    = 0;
    mem_rdy = 100;
    max_lat = 0;
    dec_rdy = 100;
    repeat (20) @(posedge clk);
    #1 h0 = nhs;
    repeat (10) @(posedge clk);
    #1;
    chk("final_stream", 32'(nhs - h0), 32'd10);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
